// File: rtl/eth_rx_crc_check.sv
// GMII receive front end: strips preamble/SFD, checks the CRC-32 FCS,
// forwards frame bytes (FCS removed) and raises a one-cycle status strobe
// at the end of every frame that reached the DATA state.
module eth_rx_crc_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_dv_i,
  input  logic        rx_er_i,
  input  logic [7:0]  rxd_i,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  output logic        out_sof_o,
  output logic        frame_done_o,
  output logic        frame_good_o,
  output logic        err_crc_o,
  output logic        err_len_o,
  output logic        err_rx_o,
  output logic [15:0] frame_len_o
);

  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;
  localparam logic [15:0] MIN_L   = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L   = 16'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t           state_q, state_d;
  logic             sfd, data_byte, data_end;
  logic [31:0]      crc_q;
  logic [15:0]      cnt_q, cnt_inc;
  logic             er_seen_q;
  logic [3:0][7:0]  dly_q;          // dly_q[3] is the oldest byte
  logic [7:0]       out_data_q;
  logic             out_valid_q, out_sof_q, done_q;
  logic             good_q, err_crc_q, err_len_q, err_rx_q;
  logic [15:0]      len_q;

  // Serial bits enter LSB first into a non-reflected register.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = (r << 1) ^ POLY;
      else              r = r << 1;
    end
    return r;
  endfunction

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus datapath control strobes.
  always_comb begin
    state_d   = state_q;
    sfd       = 1'b0;
    data_byte = 1'b0;
    data_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_dv_i) state_d = (rxd_i == 8'h55) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!rx_dv_i)             state_d = IDLE;
        else if (rx_er_i)         state_d = DROP;
        else if (rxd_i == 8'h55)  state_d = PREAMBLE;
        else if (rxd_i == 8'hD5) begin
          state_d = DATA;
          sfd     = 1'b1;
        end
        else                      state_d = DROP;
      end
      DATA: begin
        if (rx_dv_i) data_byte = 1'b1;
        else begin
          data_end = 1'b1;
          state_d  = IDLE;
        end
      end
      DROP: begin
        if (!rx_dv_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // CRC, byte counter, 4-byte delay line and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q       <= '0;
      cnt_q       <= '0;
      er_seen_q   <= 1'b0;
      dly_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      done_q      <= 1'b0;
      good_q      <= 1'b0;
      err_crc_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_rx_q    <= 1'b0;
      len_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      done_q      <= 1'b0;
      good_q      <= 1'b0;
      err_crc_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_rx_q    <= 1'b0;
      len_q       <= '0;
      if (sfd) begin
        crc_q     <= 32'hFFFFFFFF;
        cnt_q     <= '0;
        er_seen_q <= 1'b0;
        dly_q     <= '0;
      end else if (data_byte) begin
        crc_q     <= crc_step(crc_q, rxd_i);
        cnt_q     <= cnt_inc;
        er_seen_q <= er_seen_q | rx_er_i;
        dly_q     <= {dly_q[2:0], rxd_i};
        // Once four bytes are buffered, the oldest one can no longer be FCS.
        if (cnt_q >= 16'd4) begin
          out_data_q  <= dly_q[3];
          out_valid_q <= 1'b1;
          out_sof_q   <= (cnt_q == 16'd4);
        end
      end else if (data_end) begin
        done_q    <= 1'b1;
        len_q     <= cnt_q;
        err_crc_q <= (crc_q != RESIDUE);
        err_len_q <= (cnt_q < MIN_L) || (cnt_q > MAX_L);
        err_rx_q  <= er_seen_q;
        good_q    <= (crc_q == RESIDUE) && (cnt_q >= MIN_L) && (cnt_q <= MAX_L) && !er_seen_q;
      end
    end
  end

  assign out_data_o   = out_data_q;
  assign out_valid_o  = out_valid_q;
  assign out_sof_o    = out_sof_q;
  assign frame_done_o = done_q;
  assign frame_good_o = good_q;
  assign err_crc_o    = err_crc_q;
  assign err_len_o    = err_len_q;
  assign err_rx_o     = err_rx_q;
  assign frame_len_o  = len_q;

endmodule
